// File: rtl/gray_decoder_if.sv
// gray_decoder_if: Gray count in, decoded count and step/error status out.
// master drives gray_in and observes status; slave is the decoder side.
interface gray_decoder_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] gray_in;
  logic [WIDTH-1:0] bin_out;
  logic             bin_valid;
  logic             step;
  logic             dir;
  logic             err;
  logic [7:0]       err_count;

  modport master (
    output gray_in,
    input  bin_out, bin_valid, step, dir, err, err_count
  );

  modport slave (
    input  gray_in,
    output bin_out, bin_valid, step, dir, err, err_count
  );
endinterface

// File: rtl/gray_decoder.sv
// gray_decoder: syncs an async Gray count, decodes to binary, flags steps/errors.
// Ports: clk, rst_n (async low), bus (gray_decoder_if.slave). Option: GRAY_DECODER_ERR_HOLD_EN.
module gray_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  gray_decoder_if.slave  bus
);

  localparam int CW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    WARMUP,
    TRACK,
    RESYNC
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];

  logic [CW-1:0]    warm_cnt_q, warm_cnt_d;
  logic [WIDTH-1:0] g_prev_q, g_prev_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             valid_q, valid_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
`ifdef GRAY_DECODER_ERR_HOLD_EN
  logic             stab_q, stab_d;
  logic             stab_done;
`endif

  function automatic logic [WIDTH-1:0] g2b(
    input logic [WIDTH-1:0] g
  );
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] g_cur;
  logic [WIDTH-1:0] dec_cur;
  logic [WIDTH-1:0] diff;
  logic             one_step;
  logic             multi;
  logic             warm_done;

  assign g_cur     = sync_q[SYNC_STAGES-1];
  assign dec_cur   = g2b(g_cur);
  assign diff      = g_cur ^ g_prev_q;
  // Exactly one bit set <=> nonzero and clearing the lowest set bit gives 0.
  assign one_step  = (diff != '0) &&
                     ((diff & (diff - WIDTH'(1))) == '0);
  assign multi     = (diff != '0) && !one_step;
  assign warm_done = (warm_cnt_q == CW'(SYNC_STAGES));

`ifdef GRAY_DECODER_ERR_HOLD_EN
  assign stab_done = (g_cur == g_prev_q) && stab_q;
`endif

  // Raw async input lands directly on the first flop.
  always_comb begin
    sync_d[0] = bus.gray_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WARMUP;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      warm_cnt_q <= '0;
      g_prev_q   <= '0;
      bin_q      <= '0;
      valid_q    <= 1'b0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
`ifdef GRAY_DECODER_ERR_HOLD_EN
      stab_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      warm_cnt_q <= warm_cnt_d;
      g_prev_q   <= g_prev_d;
      bin_q      <= bin_d;
      valid_q    <= valid_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
`ifdef GRAY_DECODER_ERR_HOLD_EN
      stab_q     <= stab_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WARMUP: begin
        if (warm_done) state_d = TRACK;
      end
      TRACK: begin
`ifdef GRAY_DECODER_ERR_HOLD_EN
        if (multi) state_d = RESYNC;
`endif
      end
      RESYNC: begin
`ifdef GRAY_DECODER_ERR_HOLD_EN
        if (stab_done) state_d = TRACK;
`endif
      end
      default: state_d = WARMUP;
    endcase
  end

  always_comb begin
    warm_cnt_d = warm_cnt_q;
    g_prev_d   = g_prev_q;
    bin_d      = bin_q;
    valid_d    = valid_q;
    step_d     = 1'b0;
    dir_d      = dir_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
`ifdef GRAY_DECODER_ERR_HOLD_EN
    stab_d     = stab_q;
`endif
    unique case (state_q)
      WARMUP: begin
        if (warm_done) begin
          bin_d    = dec_cur;
          g_prev_d = g_cur;
          valid_d  = 1'b1;
        end else begin
          warm_cnt_d = warm_cnt_q + CW'(1);
        end
      end
      TRACK: begin
        g_prev_d = g_cur;
        unique case (1'b1)
          one_step: begin
            bin_d  = dec_cur;
            step_d = 1'b1;
            // A single Gray step is +/-1, so "not +1" means down.
            dir_d  = (dec_cur == bin_q + WIDTH'(1));
          end
          multi: begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
`ifdef GRAY_DECODER_ERR_HOLD_EN
            valid_d = 1'b0;
            stab_d  = 1'b0;
`else
            bin_d   = dec_cur;
`endif
          end
          default: ;
        endcase
      end
      RESYNC: begin
`ifdef GRAY_DECODER_ERR_HOLD_EN
        g_prev_d = g_cur;
        if (g_cur == g_prev_q) begin
          if (stab_q) begin
            bin_d   = dec_cur;
            valid_d = 1'b1;
            stab_d  = 1'b0;
          end else begin
            stab_d = 1'b1;
          end
        end else begin
          stab_d = 1'b0;
        end
`endif
      end
      default: ;
    endcase
  end

  assign bus.bin_out   = bin_q;
  assign bus.bin_valid = valid_q;
  assign bus.step      = step_q;
  assign bus.dir       = dir_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_gray_decoder.sv
// tb_gray_decoder: random and directed stimulus vs. a queue-based model.
// Outputs compared every falling edge; directed cases pin literal values.
module tb_gray_decoder;

  localparam int W = 4;
  localparam int S = 2;

  logic clk;
  logic rst_n;

  gray_decoder_if #(.WIDTH(W)) bus ();

  gray_decoder #(
    .WIDTH(W),
    .SYNC_STAGES(S)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int step_cnt = 0;

  function automatic logic [W-1:0] to_gray(input int v);
    int m;
    m = v % (1 << W);
    return W'(m ^ (m >> 1));
  endfunction

  function automatic int from_gray(input logic [W-1:0] g);
    int b;
    b = 0;
    for (int k = 0; k < W; k++) b = b ^ (int'(g) >> k);
    return b;
  endfunction

  // Behavioural model: a queue stands in for the synchronizer delay.
  logic [W-1:0] pipe[$];
  logic [W-1:0] m_g;
  logic [W-1:0] m_prev;
  int m_edges, m_mode, m_stab, m_bin, m_cnt, m_h;
  bit m_valid, m_step, m_err, m_dir;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe = {};
      for (int i = 0; i < S; i++) pipe.push_back('0);
      m_edges = 0; m_mode = 0; m_stab = 0;
      m_bin = 0; m_cnt = 0; m_prev = '0;
      m_valid = 0; m_step = 0; m_err = 0; m_dir = 0;
    end else begin
      m_g = pipe.pop_front();
      pipe.push_back(bus.gray_in);
      m_step = 0;
      m_err = 0;
      if (m_mode == 0) begin
        m_edges++;
        if (m_edges > S) begin
          m_bin = from_gray(m_g);
          m_prev = m_g;
          m_valid = 1;
          m_mode = 1;
        end
      end else if (m_mode == 1) begin
        m_h = $countones(m_g ^ m_prev);
        m_prev = m_g;
        if (m_h == 1) begin
          m_dir = (from_gray(m_g) == (m_bin + 1) % (1 << W));
          m_bin = from_gray(m_g);
          m_step = 1;
        end else if (m_h >= 2) begin
          m_err = 1;
          if (m_cnt < 255) m_cnt++;
`ifdef GRAY_DECODER_ERR_HOLD_EN
          m_valid = 0;
          m_mode = 2;
          m_stab = 0;
`else
          m_bin = from_gray(m_g);
`endif
        end
      end else begin
        if (m_g == m_prev) m_stab++;
        else m_stab = 0;
        m_prev = m_g;
        if (m_stab == 2) begin
          m_bin = from_gray(m_g);
          m_valid = 1;
          m_mode = 1;
          m_stab = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ({bus.bin_out, bus.bin_valid, bus.step, bus.dir,
           bus.err, bus.err_count} !==
          {W'(m_bin), m_valid, m_step, m_dir, m_err, 8'(m_cnt)}) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t got bin=%0d v=%0b st=%0b d=%0b e=%0b c=%0d exp bin=%0d v=%0b st=%0b d=%0b e=%0b c=%0d",
                 $time, bus.bin_out, bus.bin_valid, bus.step, bus.dir,
                 bus.err, bus.err_count, m_bin, m_valid, m_step,
                 m_dir, m_err, m_cnt);
      end
      if (bus.step) step_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] g);
    @(negedge clk);
    bus.gray_in = g;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic warmup_check(input string tag);
    wait_n(S);
    chk({tag, "_valid_early"}, 32'(bus.bin_valid), 0);
    wait_n(1);
    chk({tag, "_valid"}, 32'(bus.bin_valid), 1);
    chk({tag, "_bin"}, 32'(bus.bin_out), 0);
    chk({tag, "_nopulse"}, 32'({bus.step, bus.err}), 0);
  endtask

  logic [W-1:0] cg;

  initial begin
    bus.gray_in = '0;
    rst_n = 1'b0;
    wait_n(2);
    rst_n = 1'b1;
    warmup_check("t1");

    step_cnt = 0;
    for (int v = 1; v <= 16; v++) begin
      drive(to_gray(v));
      wait_n(9);
    end
    chk("t2_steps", 32'(step_cnt), 16);
    chk("t2_bin_wrap", 32'(bus.bin_out), 0);
    chk("t2_dir_wrap", 32'(bus.dir), 1);
    chk("t2_errcnt", 32'(bus.err_count), 0);

    drive(4'b1000);
    wait_n(4);
    chk("t3_bin15", 32'(bus.bin_out), 15);
    chk("t3_dir15", 32'(bus.dir), 0);
    drive(4'b1001);
    wait_n(4);
    chk("t3_bin14", 32'(bus.bin_out), 14);
    chk("t3_dir14", 32'(bus.dir), 0);

    drive(4'b0001);
    wait_n(4);
    drive(4'b0100);
    wait_n(S + 1);
    chk("t4_err", 32'(bus.err), 1);
    chk("t4_step", 32'(bus.step), 0);
    chk("t4_errcnt", 32'(bus.err_count), 1);
`ifdef GRAY_DECODER_ERR_HOLD_EN
    chk("t4_hold_bin", 32'(bus.bin_out), 1);
    chk("t4_hold_valid", 32'(bus.bin_valid), 0);
    wait_n(1);
    chk("t4_err_pulse", 32'(bus.err), 0);
    wait_n(1);
    chk("t4_reload_valid", 32'(bus.bin_valid), 1);
    chk("t4_reload_bin", 32'(bus.bin_out), 7);
`else
    chk("t4_bin", 32'(bus.bin_out), 7);
    wait_n(1);
    chk("t4_err_pulse", 32'(bus.err), 0);
`endif
    wait_n(4);

    cg = bus.gray_in;
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r >= 50 && r < 85) cg = cg ^ W'(1 << $urandom_range(0, W - 1));
      else if (r >= 85) cg = W'($urandom);
      drive(cg);
    end

    drive(4'b0000);
    wait_n(6);
    for (int i = 0; i < 300; i++) begin
      drive((i % 2 == 0) ? 4'b0011 : 4'b0000);
      wait_n(3);
    end
    wait_n(4);
    chk("t5_sat", 32'(bus.err_count), 255);

    drive(to_gray(9));
    wait_n(6);
    chk("t6_bin9", 32'(bus.bin_out), 9);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    bus.gray_in = '0;
    #1;
    chk("t6_bin", 32'(bus.bin_out), 0);
    chk("t6_valid", 32'(bus.bin_valid), 0);
    chk("t6_pulses", 32'({bus.step, bus.err, bus.dir}), 0);
    chk("t6_errcnt", 32'(bus.err_count), 0);
    wait_n(2);
    rst_n = 1'b1;
    warmup_check("t6w");
    wait_n(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
